// File: rtl/alu_issue_stage.sv
// Issue/capture stage wrapped around the 4-bit combinational ALU:
// valid/ready intake, registered ALU pin drive, captured result released on valid/ready.
module alu_issue_stage #(
    parameter int N     = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_a,
    input  logic [N-1:0]     in_b,
    input  logic             in_c0,
    input  logic [2:0]       in_op,
    output logic [N-1:0]     alu_a,
    output logic [N-1:0]     alu_b,
    output logic             alu_c0,
    output logic             alu_m,
    output logic             alu_s1,
    output logic             alu_s0,
    input  logic [N-1:0]     alu_data,
    input  logic             alu_cout,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [N-1:0]     res_data,
    output logic             res_cout,
    output logic             res_zero,
    output logic [2:0]       res_op,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_q;
    state_t         state_d;
    logic [N-1:0]   a_q;
    logic [N-1:0]   b_q;
    logic           c0_q;
    logic [2:0]     op_q;
    logic           accept;
    logic           consume;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = EXEC;
            EXEC:    state_d = DONE;
            DONE:    if (res_ready) state_d = in_valid ? EXEC : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // in_ready is forced low for the whole time reset is held
    always_comb begin
        in_ready  = 1'b0;
        res_valid = 1'b0;
        if (!rst) begin
            case (state_q)
                IDLE: in_ready = 1'b1;
                DONE: begin
                    res_valid = 1'b1;
                    in_ready  = res_ready;
                end
                default: ;
            endcase
        end
    end

    assign accept  = in_valid & in_ready;
    assign consume = res_valid & res_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q  <= '0;
            b_q  <= '0;
            c0_q <= 1'b0;
            op_q <= '0;
        end else if (accept) begin
            a_q  <= in_a;
            b_q  <= in_b;
            c0_q <= in_c0;
            op_q <= in_op;
        end
    end

    assign alu_a  = a_q;
    assign alu_b  = b_q;
    assign alu_c0 = c0_q;
    assign alu_m  = op_q[2];
    assign alu_s1 = op_q[1];
    assign alu_s0 = op_q[0];

    // Gating with M keeps a floating C_out from logic ops out of res_cout
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_data <= '0;
            res_cout <= 1'b0;
            res_zero <= 1'b0;
            res_op   <= '0;
        end else if (state_q == EXEC) begin
            res_data <= alu_data;
            res_cout <= op_q[2] & alu_cout;
            res_zero <= (alu_data == '0);
            res_op   <= op_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)          op_count <= '0;
        else if (consume) op_count <= op_count + CNT_W'(1);
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: behavioural ALU on the ALU pins, a scoreboard model of the
// stage checked every cycle, and directed vectors with hand-computed results.
module tb_alu_issue_stage;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [3:0] in_a;
    logic [3:0] in_b;
    logic       in_c0;
    logic [2:0] in_op;
    logic       res_ready;
    logic [3:0] alu_data;
    logic       alu_cout;
    logic       logic_cout;

    logic       in_ready,  res_valid,  res_cout,  res_zero;
    logic [3:0] alu_a,     alu_b,      res_data;
    logic       alu_c0,    alu_m,      alu_s1,    alu_s0;
    logic [2:0] res_op;
    logic [7:0] op_count;

    logic       in_ready2, res_valid2, res_cout2, res_zero2;
    logic [3:0] alu_a2,    alu_b2,     res_data2;
    logic       alu_c02,   alu_m2,     alu_s12,   alu_s02;
    logic [2:0] res_op2;
    logic [1:0] op_count2;

    int unsigned errors = 0;
    int unsigned checks = 0;

    always #5 clk = ~clk;

    alu_issue_stage #(.N(4), .CNT_W(8)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_c0(in_c0), .in_op(in_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_c0(alu_c0), .alu_m(alu_m),
        .alu_s1(alu_s1), .alu_s0(alu_s0), .alu_data(alu_data), .alu_cout(alu_cout),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_cout(res_cout), .res_zero(res_zero), .res_op(res_op), .op_count(op_count)
    );

    // Narrow-counter twin on the same inputs; only its op_count is of interest
    alu_issue_stage #(.N(4), .CNT_W(2)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .in_a(in_a), .in_b(in_b), .in_c0(in_c0), .in_op(in_op),
        .alu_a(alu_a2), .alu_b(alu_b2), .alu_c0(alu_c02), .alu_m(alu_m2),
        .alu_s1(alu_s12), .alu_s0(alu_s02), .alu_data(alu_data), .alu_cout(alu_cout),
        .res_valid(res_valid2), .res_ready(res_ready), .res_data(res_data2),
        .res_cout(res_cout2), .res_zero(res_zero2), .res_op(res_op2), .op_count(op_count2)
    );

    function automatic logic [4:0] alu_fn(input logic [2:0] op, input logic [3:0] a,
                                          input logic [3:0] b, input logic c0);
        logic [4:0] ea, eb, ena, enb;
        ea  = {1'b0, a};
        eb  = {1'b0, b};
        ena = {1'b0, ~a};
        enb = {1'b0, ~b};
        case (op)
            3'd0:    return {1'b0, a & b};
            3'd1:    return {1'b0, a | b};
            3'd2:    return {1'b0, a ^ b};
            3'd3:    return {1'b0, ~(a ^ b)};
            3'd4:    return ea + 5'(c0);
            3'd5:    return ea + eb + 5'(c0);
            3'd6:    return ea + enb + 5'(c0);
            default: return ena + eb + 5'(c0);
        endcase
    endfunction

    // Behavioural ALU; for logic ops C_out carries whatever logic_cout says (Z or junk)
    always_comb begin
        logic [4:0] r;
        r        = alu_fn({alu_m, alu_s1, alu_s0}, alu_a, alu_b, alu_c0);
        alu_data = r[3:0];
        alu_cout = alu_m ? r[4] : logic_cout;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- scoreboard model ----------------
    typedef struct {
        logic [3:0] data;
        logic       cout;
        logic [2:0] op;
        bit         aged;
    } exp_t;

    exp_t        q[$];
    int unsigned model_count;
    logic [3:0]  last_a, last_b;
    logic        last_c0;
    logic [2:0]  last_op;

    function automatic bit exp_valid();
        return (q.size() > 0) && q[0].aged;
    endfunction

    function automatic bit exp_in_ready();
        return (q.size() == 0) || (q[0].aged && res_ready);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            model_count = 0;
            last_a = '0; last_b = '0; last_c0 = 1'b0; last_op = '0;
        end else begin
            bit cons, acc;
            cons = exp_valid() && res_ready;
            acc  = in_valid && exp_in_ready();
            if (cons) begin
                void'(q.pop_front());
                model_count++;
            end
            foreach (q[i]) q[i].aged = 1'b1;
            if (acc) begin
                exp_t e;
                logic [4:0] r;
                r      = alu_fn(in_op, in_a, in_b, in_c0);
                e.data = r[3:0];
                e.cout = in_op[2] ? r[4] : 1'b0;
                e.op   = in_op;
                e.aged = 1'b0;
                q.push_back(e);
                last_a = in_a; last_b = in_b; last_c0 = in_c0; last_op = in_op;
            end
        end
    end

    always begin
        @(negedge clk);
        #2;
        if (!rst) begin
            chk("m_in_ready", in_ready, exp_in_ready());
            chk("m_res_valid", res_valid, exp_valid());
            chk("m_op_count", op_count, model_count % 256);
            chk("m_op_count_w2", op_count2, model_count % 4);
            chk("m_alu_a", alu_a, last_a);
            chk("m_alu_b", alu_b, last_b);
            chk("m_alu_c0", alu_c0, last_c0);
            chk("m_alu_sel", {alu_m, alu_s1, alu_s0}, last_op);
            if (exp_valid()) begin
                chk("m_res_data", res_data, q[0].data);
                chk("m_res_cout", res_cout, q[0].cout);
                chk("m_res_zero", res_zero, q[0].data == 4'd0);
                chk("m_res_op", res_op, q[0].op);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic do_op(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                         input logic c0);
        @(negedge clk);
        in_op = op; in_a = a; in_b = b; in_c0 = c0; in_valid = 1'b1;
        #1;
        for (int g = 0; g < 50 && !in_ready; g++) begin
            @(negedge clk);
            #1;
        end
        if (!in_ready) chk("accept_timeout", 0, 1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_result();
        #1;
        for (int g = 0; g < 20 && !res_valid; g++) begin
            @(negedge clk);
            #1;
        end
        if (!res_valid) chk("result_timeout", 0, 1);
    endtask

    task automatic consume();
        @(negedge clk);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    task automatic set_ops(input int i);
        in_op = 3'(i % 8);
        in_a  = 4'(i + 3);
        in_b  = 4'(2 * i + 1);
        in_c0 = 1'(i & 1);
    endtask

    initial begin
        int unsigned cycles;
        int idx;
        rst = 1'b1; in_valid = 1'b0; res_ready = 1'b0; logic_cout = 1'bz;
        in_a = '0; in_b = '0; in_c0 = 1'b0; in_op = '0;
        #12;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_op_count", op_count, 0);
        chk("rst_res_data", res_data, 0);
        @(negedge clk);
        rst = 1'b0;

        // 3+5: result visible on the edge after the accept edge, not before
        do_op(3'd5, 4'h3, 4'h5, 1'b0);
        #1;
        chk("lat_exec_not_valid", res_valid, 0);
        @(negedge clk);
        #1;
        chk("lat_done_valid", res_valid, 1);
        chk("t1_data", res_data, 8);
        chk("t1_cout", res_cout, 0);
        chk("t1_zero", res_zero, 0);
        consume();

        do_op(3'd5, 4'h9, 4'h9, 1'b0);
        wait_result();
        chk("t2a_data", res_data, 2);
        chk("t2a_cout", res_cout, 1);
        consume();
        do_op(3'd6, 4'h5, 4'h3, 1'b1);
        wait_result();
        chk("t2b_data", res_data, 2);
        chk("t2b_cout", res_cout, 1);
        consume();

        do_op(3'd0, 4'hC, 4'hA, 1'b0);
        wait_result();
        chk("t3a_data", res_data, 8);
        chk("t3a_cout_z", res_cout, 0);
        consume();
        logic_cout = 1'b1;
        do_op(3'd2, 4'hF, 4'hF, 1'b0);
        wait_result();
        chk("t3b_data", res_data, 0);
        chk("t3b_zero", res_zero, 1);
        chk("t3b_cout_junk", res_cout, 0);
        consume();
        logic_cout = 1'bz;

        // Held result with a new request waiting: ~2+6 = 19 -> data 3, carry 1
        do_op(3'd7, 4'h2, 4'h6, 1'b0);
        wait_result();
        @(negedge clk);
        in_op = 3'd1; in_a = 4'h1; in_b = 4'h2; in_c0 = 1'b0; in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("t4_hold_data", res_data, 3);
            chk("t4_hold_cout", res_cout, 1);
            chk("t4_hold_op", res_op, 7);
            chk("t4_hold_in_ready", in_ready, 0);
            chk("t4_hold_count", op_count, 5);
            @(negedge clk);
        end
        res_ready = 1'b1;
        #1;
        chk("t4_release_in_ready", in_ready, 1);
        @(negedge clk);
        res_ready = 1'b0; in_valid = 1'b0;
        #1;
        chk("t4_count_inc", op_count, 6);
        chk("t4_exec_not_valid", res_valid, 0);
        wait_result();
        chk("t4_next_data", res_data, 3);
        chk("t4_next_op", res_op, 1);
        consume();
        chk("t4_final_count", op_count, 7);

        // Back-to-back stream after a fresh reset
        @(negedge clk);
        rst = 1'b1;
        #1;
        rst = 1'b0;
        @(negedge clk);
        res_ready = 1'b1; in_valid = 1'b1; set_ops(0);
        idx = 0; cycles = 0;
        for (int g = 0; g < 100 && idx < 10; g++) begin
            #1;
            if (in_ready) begin
                @(negedge clk);
                idx++;
                if (idx < 10) set_ops(idx);
                else in_valid = 1'b0;
            end else begin
                @(negedge clk);
            end
            cycles++;
        end
        chk("t5_ops_accepted", idx, 10);
        chk("t5_cycles", cycles, 19);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("t5_count", op_count, 10);
        chk("t5_count_w2", op_count2, 2);
        res_ready = 1'b0;

        // Reset in the middle of EXEC
        do_op(3'd5, 4'h4, 4'h4, 1'b0);
        #3;
        rst = 1'b1;
        #1;
        chk("t6_res_valid", res_valid, 0);
        chk("t6_in_ready", in_ready, 0);
        chk("t6_res_data", res_data, 0);
        chk("t6_res_op", res_op, 0);
        chk("t6_op_count", op_count, 0);
        chk("t6_alu_a", alu_a, 0);
        chk("t6_alu_sel", {alu_m, alu_s1, alu_s0}, 0);
        @(negedge clk);
        rst = 1'b0;
        do_op(3'd5, 4'h7, 4'h8, 1'b1);
        wait_result();
        chk("t6_after_data", res_data, 0);
        chk("t6_after_cout", res_cout, 1);
        chk("t6_after_zero", res_zero, 1);
        consume();
        #1;
        chk("t6_after_count", op_count, 1);

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
